// File: rtl/clkdiv_ctrl.sv
// Programmable clock-enable divider with glitch-free divisor switching.
// Optional completed-period counter enabled by CLKDIV_PERIOD_CNT_EN.
module clkdiv_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 25
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] active_div,
    output logic [31:0]      period_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             running;
    logic             boundary;
    logic             xfer;
    logic             div_ok;

    assign running  = (state_q != IDLE);
    assign boundary = running && (cnt_q == div_q - CNT_W'(1));
    assign xfer     = cfg_valid && !pend_vld_q;
    assign div_ok   = (cfg_div >= CNT_W'(2));

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for every registered output, derived from next state.
    always_comb begin
        cnt_d      = (running && !boundary) ? cnt_q + CNT_W'(1) : '0;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = 1'b0;
        if (boundary && pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        if (xfer) begin
            if (!div_ok) begin
                err_d = 1'b1;
            end else if (!running) begin
                div_d = cfg_div;
            end else begin
                pend_d     = cfg_div;
                pend_vld_d = 1'b1;
            end
        end
        clk_d  = (state_d != IDLE) && (cnt_d < (div_d >> 1));
        tick_d = (state_d != IDLE) && (cnt_d == '0);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [31:0] pc_q, pc_d;

    assign pc_d = boundary ? pc_q + 32'd1 : pc_q;

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign period_cnt = pc_q;
`else
    assign period_cnt = '0;
`endif

    assign cfg_ready  = !pend_vld_q;
    assign cfg_err    = err_q;
    assign clk_out    = clk_q;
    assign tick       = tick_q;
    assign busy       = running;
    assign active_div = div_q;

endmodule
